// File: rtl/dma_copy_if.sv
// Bus bundle for dma_copy: the CPU-facing config responder signals plus the
// initiator signals the engine drives onto the shared memory bus.
interface dma_copy_if;
    // config responder port
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;
    // initiator port
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [31:0] read_value_in;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic        ready_in;
    logic        fault_in;
    logic        done_out;

    // slave: the copy engine's view of the bundle
    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in,
        output read_value_out, ready_out,
        output address_out, read_out, write_out, write_mask_out, write_value_out,
        input  read_value_in, ready_in, fault_in,
        output done_out
    );

    // master: the system side (CPU decode, arbiter, memory)
    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out,
        input  address_out, read_out, write_out, write_mask_out, write_value_out,
        output read_value_in, ready_in, fault_in,
        input  done_out
    );
endinterface

// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy engine: a programmable register file
// on the config port and a read/write-pair state machine on the initiator port.
module dma_copy #(
    parameter int COUNT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    dma_copy_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [31:0]           r_src;
    logic [31:0]           r_dst;
    logic [31:0]           r_buf;
    logic [COUNT_BITS-1:0] r_count;
    logic                  r_done;
    logic                  r_fault;

    logic        w_busy;
    logic [1:0]  w_reg_sel;
    logic        w_cfg_wr;
    logic        w_reg_wr;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_xfer_ok;
    logic        w_xfer_fault;
    logic        w_last_word;
    logic [31:0] w_lane_mask;
    logic [31:0] w_src_merged;
    logic [31:0] w_dst_merged;
    logic [COUNT_BITS-1:0] w_count_merged;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_busy       = (r_state != S_IDLE);
    assign w_reg_sel    = bus.address_in[3:2];
    assign w_cfg_wr     = bus.sel_in & (|bus.write_mask_in);
    assign w_reg_wr     = w_cfg_wr & ~w_busy;
    assign w_ctrl_wr    = w_reg_wr & (w_reg_sel == 2'd3) & bus.write_mask_in[0];
    assign w_start      = w_ctrl_wr & bus.write_value_in[0];
    assign w_xfer_ok    = bus.ready_in & ~bus.fault_in;
    assign w_xfer_fault = bus.ready_in & bus.fault_in;
    assign w_last_word  = (r_count == COUNT_BITS'(1));
    assign w_unused     = &{1'b0, bus.read_in, bus.address_in[31:4], bus.address_in[1:0]};

    // Expand byte-lane enables into a bit mask for read-modify-write merges.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane_mask[gi*8 +: 8] = {8{bus.write_mask_in[gi]}};
    end

    // Pointers are word-aligned, so the low two bits are forced to zero.
    assign w_src_merged   = ((r_src & ~w_lane_mask) | (bus.write_value_in & w_lane_mask)) & 32'hFFFF_FFFC;
    assign w_dst_merged   = ((r_dst & ~w_lane_mask) | (bus.write_value_in & w_lane_mask)) & 32'hFFFF_FFFC;
    assign w_count_merged = (r_count & ~w_lane_mask[COUNT_BITS-1:0])
                          | (bus.write_value_in[COUNT_BITS-1:0] & w_lane_mask[COUNT_BITS-1:0]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start && r_count != '0) w_state_next = S_RD;
            S_RD: begin
                if (w_xfer_fault)   w_state_next = S_IDLE;
                else if (w_xfer_ok) w_state_next = S_WR;
            end
            S_WR: begin
                if (w_xfer_fault)   w_state_next = S_IDLE;
                else if (w_xfer_ok) w_state_next = w_last_word ? S_IDLE : S_RD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.read_out        = 1'b0;
        bus.write_out       = 1'b0;
        bus.address_out     = 32'h0;
        bus.write_mask_out  = 4'b0000;
        bus.write_value_out = 32'h0;
        case (r_state)
            S_RD: begin
                bus.read_out    = 1'b1;
                bus.address_out = r_src;
            end
            S_WR: begin
                bus.write_out       = 1'b1;
                bus.address_out     = r_dst;
                bus.write_mask_out  = 4'b1111;
                bus.write_value_out = r_buf;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_reg_sel)
            2'd0: w_rdata = r_src;
            2'd1: w_rdata = r_dst;
            2'd2: w_rdata = {{(32-COUNT_BITS){1'b0}}, r_count};
            2'd3: w_rdata = {29'b0, r_fault, r_done, w_busy};
            default: w_rdata = 32'h0;
        endcase
    end

    assign bus.read_value_out = bus.sel_in ? w_rdata : 32'h0;
    assign bus.ready_out      = bus.sel_in;
    assign bus.done_out       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= 32'h0;
            r_dst   <= 32'h0;
            r_buf   <= 32'h0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_reg_wr && w_reg_sel == 2'd0) r_src   <= w_src_merged;
            if (w_reg_wr && w_reg_sel == 2'd1) r_dst   <= w_dst_merged;
            if (w_reg_wr && w_reg_sel == 2'd2) r_count <= w_count_merged;
            if (w_ctrl_wr) begin
                r_done  <= 1'b0;
                r_fault <= 1'b0;
            end
            // A zero-length start completes immediately without touching the bus.
            if (w_start && r_count == '0) r_done <= 1'b1;
            if (r_state == S_RD && w_xfer_ok) r_buf <= bus.read_value_in;
            if (r_state == S_WR && w_xfer_ok) begin
                r_src   <= r_src + 32'd4;
                r_dst   <= r_dst + 32'd4;
                r_count <= r_count - COUNT_BITS'(1);
                if (w_last_word) r_done <= 1'b1;
            end
            if (r_state != S_IDLE && w_xfer_fault) r_fault <= 1'b1;
        end
    end
endmodule

// File: doc/dma_copy.md
# dma_copy

Word-granular memory-to-memory copy engine on the common memory bus. It has two ports. The first is a responder port, decoded like any other peripheral: the CPU programs source, destination and length, then starts the engine. The second is an initiator port, which the bus arbiter services as an additional, lowest-priority master. Through it the engine issues read/write pairs until the count is exhausted or the bus reports a fault.

## Interface
Parameters:
- COUNT_BITS, 16, width of the word-count register; a transfer is at most 2^COUNT_BITS-1 words.

Ports:
- clk  in  1  system clock (pll_clk domain)
- reset  in  1  synchronous, active-high reset
- address_in  in  32  config port address; only bits [3:2] are decoded
- sel_in  in  1  config port select from top-level decode
- read_in  in  1  config read strobe
- read_value_out  out  32  config read data; 0 when sel_in=0 (OR-combined bus)
- write_mask_in  in  4  config byte-lane write enables
- write_value_in  in  32  config write data
- ready_out  out  1  config ready; equals sel_in (zero wait states)
- address_out  out  32  initiator address, always word-aligned
- read_out  out  1  initiator read request
- write_out  out  1  initiator write request
- read_value_in  in  32  initiator read data; valid when ready_in=1
- write_mask_out  out  4  4'b1111 during write, 4'b0000 otherwise
- write_value_out  out  32  initiator write data
- ready_in  in  1  initiator transaction complete
- fault_in  in  1  initiator transaction faulted; qualified by ready_in
- done_out  out  1  level copy of STATUS.done, for polling or an interrupt line

## Operation
- Register map (address_in[3:2]):
  - 0 SRC: source pointer; bits [1:0] read 0 and ignore writes.
  - 1 DST: destination pointer; same alignment rule as SRC.
  - 2 COUNT: words remaining, in [COUNT_BITS-1:0]; upper bits read 0.
  - 3 CTRL/STATUS: read returns {29'b0, fault, done, busy}.
- Config writes honour write_mask_in per byte lane.
- While busy=1, writes to SRC, DST and COUNT are ignored. They remain readable and show live progress.
- CTRL write with lane 0 enabled:
  - If busy=0 and bit0=1: clear done and fault, then start.
  - If busy=0 and bit0=0: clear done and fault only.
  - If busy=1: the write is ignored.
- State machine IDLE, RD, WR:
  - IDLE, on start:
    - COUNT=0: done<=1, stay in IDLE. No bus traffic.
    - COUNT≠0: busy<=1, go to RD.
  - RD:
    - Drive read_out=1, address_out=SRC, write_mask_out=0.
    - On ready_in & !fault_in: latch read_value_in into the data buffer, go to WR.
  - WR:
    - Drive write_out=1, address_out=DST, write_mask_out=4'b1111, write_value_out=buffer.
    - On ready_in & !fault_in: SRC+=4, DST+=4, COUNT-=1.
    - If the old COUNT was 1: busy<=0, done<=1, go to IDLE. Otherwise go to RD.
  - RD or WR, on ready_in & fault_in:
    - fault<=1, busy<=0, go to IDLE.
    - SRC, DST and COUNT keep the values of the faulting transaction; no increment.
- Pointer arithmetic is modulo 2^32; wrap is not detected.
- Overlapping regions are copied in ascending address order with no hazard handling.

## Timing
- Reset values:
  - All registers 0; state IDLE.
  - read_out, write_out, write_mask_out, address_out, write_value_out all 0.
  - done_out 0; read_value_out 0.
- Reset mid-transfer aborts on the next edge. Bus outputs are 0 the following cycle, with no partial write.
- Initiator handshake:
  - Request signals stay stable from assertion until the cycle ready_in=1.
  - The transaction completes in that cycle.
  - The next request may assert in the very next cycle.
  - read_out and write_out are never high together. Both are 0 in IDLE.
- Start latency: a CTRL start written in cycle N gives read_out=1 in cycle N+1.
- Throughput: minimum 2 cycles per word when ready_in returns in the request cycle. Each wait state adds one cycle.
- Completion: when the final write is accepted in cycle M, busy=0, done=1 and done_out=1 are visible in cycle M+1.
- Config reads are combinational from registers, so a read returns the pre-edge value.
- A CTRL write in the same cycle as final completion sees busy=1 and is ignored.

## Test plan
- Reset: hold reset 2 cycles → all bus outputs 0, STATUS reads 0, done_out=0.
- Basic copy: ram preloaded 0x10000000..0x1000000C = 11,22,33,44; SRC=0x10000000, DST=0x10000100, COUNT=4, start → 4 read/write pairs alternating; 0x10000100..0x1000010C = 11,22,33,44; STATUS=0b010; SRC=0x10000010; COUNT=0; 8 cycles with zero-wait ram.
- Zero count: COUNT=0, start → no read_out/write_out ever asserted, done=1 the next cycle.
- Fault: DST=0x20000000 (unmapped), COUNT=3 → first write faults; STATUS=0b100; COUNT=3, DST=0x20000000 unchanged; bus idle.
- Busy lockout and wait states: ready_in delayed 3 cycles per transaction; writes to SRC/COUNT and a second start mid-transfer → ignored; requests held stable through waits; a CTRL write with bit0=0 after completion clears done.
- Abort: assert reset during WR of word 2 of 4 → bus outputs 0 next cycle, destination word 2 unwritten, STATUS=0.
